// File: rtl/calc1_pkg.sv
// calc1_pkg: shared constants, port-state enum and round-robin helper for the calc1 request scheduler.
package calc1_pkg;
   localparam int NPORTS = 4;
   localparam int DW = 32;
   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;
   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK = 2'd1;
   localparam logic [1:0] RESP_ERR = 2'd2;
   typedef enum logic [2:0] {IDLE, OP2, PEND, ERR, BUSY} port_state_e;
   function automatic logic is_valid_cmd(input logic [3:0] cmd);
      return cmd inside {CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR};
   endfunction
   // First pending port after 'last'; 'last' itself has the lowest priority.
   function automatic logic [1:0] rr_pick(input logic [NPORTS-1:0] pend, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int k = NPORTS; k >= 1; k--) begin
         idx = last + 2'(k);
         if (pend[idx]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/calc1_port_ctrl.sv
// calc1_port_ctrl: one requester port: two-cycle command capture, local error answer, registered response.
module calc1_port_ctrl
   import calc1_pkg::*;
(
   input  logic          c_clk,
   input  logic          reset_n,
   input  logic [3:0]    i_cmd,
   input  logic [DW-1:0] i_data,
   input  logic          i_grant,
   input  logic          i_resp_valid,
   input  logic [1:0]    i_resp,
   input  logic [DW-1:0] i_resp_data,
   output logic          o_pend,
   output logic [3:0]    o_cmd,
   output logic [DW-1:0] o_op1,
   output logic [DW-1:0] o_op2,
   output logic [1:0]    o_resp,
   output logic [DW-1:0] o_data
);
   port_state_e r_state, w_next;
   logic [3:0] r_cmd;
   logic [DW-1:0] r_op1, r_op2, r_data;
   logic [1:0] r_resp;
   logic w_done;

   assign w_done = r_state == BUSY && i_resp_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: w_next = i_cmd != CMD_NOP ? OP2 : IDLE;
         OP2: w_next = is_valid_cmd(r_cmd) ? PEND : ERR;
         PEND: w_next = i_grant ? BUSY : PEND;
         ERR: w_next = IDLE;
         BUSY: w_next = i_resp_valid ? IDLE : BUSY;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cmd <= CMD_NOP;
         r_op1 <= '0;
         r_op2 <= '0;
         r_resp <= RESP_NONE;
         r_data <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && i_cmd != CMD_NOP) begin
            r_cmd <= i_cmd;
            r_op1 <= i_data;
         end
         if (r_state == OP2) r_op2 <= i_data;
         r_resp <= r_state == ERR ? RESP_ERR : w_done ? i_resp : RESP_NONE;
         r_data <= w_done ? i_resp_data : '0;
      end
   end

   assign o_pend = r_state == PEND;
   assign o_cmd = r_cmd;
   assign o_op1 = r_op1;
   assign o_op2 = r_op2;
   assign o_resp = r_resp;
   assign o_data = r_data;
endmodule

// File: rtl/calc1_port_sched.sv
// calc1_port_sched: four-port round-robin scheduler in front of the shared calc1 ALU,
// with tagged out-of-order result routing.
module calc1_port_sched
   import calc1_pkg::*;
(
   input  logic          c_clk,
   input  logic          reset_n,
   input  logic [3:0]    req1_cmd_in,
   input  logic [3:0]    req2_cmd_in,
   input  logic [3:0]    req3_cmd_in,
   input  logic [3:0]    req4_cmd_in,
   input  logic [DW-1:0] req1_data_in,
   input  logic [DW-1:0] req2_data_in,
   input  logic [DW-1:0] req3_data_in,
   input  logic [DW-1:0] req4_data_in,
   output logic [1:0]    out_resp1,
   output logic [1:0]    out_resp2,
   output logic [1:0]    out_resp3,
   output logic [1:0]    out_resp4,
   output logic [DW-1:0] out_data1,
   output logic [DW-1:0] out_data2,
   output logic [DW-1:0] out_data3,
   output logic [DW-1:0] out_data4,
   output logic          alu_req_valid,
   input  logic          alu_req_ready,
   output logic [3:0]    alu_cmd,
   output logic [DW-1:0] alu_op1,
   output logic [DW-1:0] alu_op2,
   output logic [1:0]    alu_tag,
   input  logic          alu_resp_valid,
   input  logic [1:0]    alu_resp,
   input  logic [DW-1:0] alu_resp_data,
   input  logic [1:0]    alu_resp_tag
);
   logic [3:0] w_req_cmd [NPORTS];
   logic [DW-1:0] w_req_data [NPORTS];
   logic [3:0] w_cmd [NPORTS];
   logic [DW-1:0] w_op1 [NPORTS];
   logic [DW-1:0] w_op2 [NPORTS];
   logic [1:0] w_resp [NPORTS];
   logic [DW-1:0] w_data [NPORTS];
   logic [NPORTS-1:0] w_pend;
   logic [1:0] w_win, r_last, r_hold_tag;
   logic r_hold, w_fire;

   assign w_req_cmd = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
   assign w_req_data = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};

   // A stalled winner stays locked so late arrivals cannot change the presented request.
   assign w_win = r_hold ? r_hold_tag : rr_pick(w_pend, r_last);
   assign alu_req_valid = |w_pend;
   assign w_fire = alu_req_valid && alu_req_ready;
   assign alu_cmd = alu_req_valid ? w_cmd[w_win] : CMD_NOP;
   assign alu_op1 = alu_req_valid ? w_op1[w_win] : '0;
   assign alu_op2 = alu_req_valid ? w_op2[w_win] : '0;
   assign alu_tag = alu_req_valid ? w_win : 2'd0;

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= 2'd3;
         r_hold <= 1'b0;
         r_hold_tag <= 2'd0;
      end else begin
         r_hold <= alu_req_valid && !alu_req_ready;
         r_hold_tag <= w_win;
         if (w_fire) r_last <= w_win;
      end
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      calc1_port_ctrl u_port (
         .c_clk       (c_clk),
         .reset_n     (reset_n),
         .i_cmd       (w_req_cmd[p]),
         .i_data      (w_req_data[p]),
         .i_grant     (w_fire && w_win == 2'(p)),
         .i_resp_valid(alu_resp_valid && alu_resp_tag == 2'(p)),
         .i_resp      (alu_resp),
         .i_resp_data (alu_resp_data),
         .o_pend      (w_pend[p]),
         .o_cmd       (w_cmd[p]),
         .o_op1       (w_op1[p]),
         .o_op2       (w_op2[p]),
         .o_resp      (w_resp[p]),
         .o_data      (w_data[p])
      );
   end

   assign out_resp1 = w_resp[0];
   assign out_resp2 = w_resp[1];
   assign out_resp3 = w_resp[2];
   assign out_resp4 = w_resp[3];
   assign out_data1 = w_data[0];
   assign out_data2 = w_data[1];
   assign out_data3 = w_data[2];
   assign out_data4 = w_data[3];
endmodule

// File: tb/tb_calc1_port_sched.sv
// tb_calc1_port_sched: directed-vector self-checking bench for calc1_port_sched.
module tb_calc1_port_sched;
   import calc1_pkg::*;
   logic c_clk, reset_n;
   logic [3:0] cmd_v [4];
   logic [31:0] dat_v [4];
   logic [3:0] req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
   logic [31:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
   logic [1:0] out_resp1, out_resp2, out_resp3, out_resp4;
   logic [31:0] out_data1, out_data2, out_data3, out_data4;
   logic [1:0] o_resp [4];
   logic [31:0] o_data [4];
   logic alu_req_valid, alu_req_ready, alu_resp_valid;
   logic [3:0] alu_cmd;
   logic [31:0] alu_op1, alu_op2, alu_resp_data;
   logic [1:0] alu_tag, alu_resp, alu_resp_tag;
   int n_chk = 0, n_err = 0;

   assign req1_cmd_in = cmd_v[0];
   assign req2_cmd_in = cmd_v[1];
   assign req3_cmd_in = cmd_v[2];
   assign req4_cmd_in = cmd_v[3];
   assign req1_data_in = dat_v[0];
   assign req2_data_in = dat_v[1];
   assign req3_data_in = dat_v[2];
   assign req4_data_in = dat_v[3];
   assign o_resp[0] = out_resp1;
   assign o_resp[1] = out_resp2;
   assign o_resp[2] = out_resp3;
   assign o_resp[3] = out_resp4;
   assign o_data[0] = out_data1;
   assign o_data[1] = out_data2;
   assign o_data[2] = out_data3;
   assign o_data[3] = out_data4;

   calc1_port_sched dut (
      .c_clk(c_clk), .reset_n(reset_n),
      .req1_cmd_in(req1_cmd_in), .req2_cmd_in(req2_cmd_in),
      .req3_cmd_in(req3_cmd_in), .req4_cmd_in(req4_cmd_in),
      .req1_data_in(req1_data_in), .req2_data_in(req2_data_in),
      .req3_data_in(req3_data_in), .req4_data_in(req4_data_in),
      .out_resp1(out_resp1), .out_resp2(out_resp2), .out_resp3(out_resp3), .out_resp4(out_resp4),
      .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
      .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
      .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_tag(alu_tag),
      .alu_resp_valid(alu_resp_valid), .alu_resp(alu_resp),
      .alu_resp_data(alu_resp_data), .alu_resp_tag(alu_resp_tag)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge c_clk);
      #1;
   endtask

   // Two-cycle request on every port in mask m: op1 = a+p, op2 = b+p.
   task automatic send(input logic [3:0] m, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      for (int p = 0; p < 4; p++) if (m[p]) begin cmd_v[p] = c; dat_v[p] = a + p; end
      tick;
      for (int p = 0; p < 4; p++) if (m[p]) begin cmd_v[p] = CMD_NOP; dat_v[p] = b + p; end
      tick;
      for (int p = 0; p < 4; p++) if (m[p]) dat_v[p] = '0;
   endtask

   task automatic result(input logic [1:0] t, input logic [1:0] r, input logic [31:0] d);
      alu_resp_valid = 1'b1;
      alu_resp_tag = t;
      alu_resp = r;
      alu_resp_data = d;
      tick;
      alu_resp_valid = 1'b0;
   endtask

   task automatic rr_round;
      send(4'hF, CMD_SUB, 32'd100, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("rr_valid", alu_req_valid, 1);
         check("rr_tag", alu_tag, i);
         check("rr_cmd", alu_cmd, CMD_SUB);
         check("rr_op1", alu_op1, 100 + i);
         check("rr_op2", alu_op2, i);
         tick;
      end
      check("rr_idle", alu_req_valid, 0);
      for (int i = 0; i < 4; i++) begin
         result(2'(i), RESP_OK, 32'h1000 + i);
         check("rr_resp", o_resp[i], RESP_OK);
         check("rr_data", o_data[i], 32'h1000 + i);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      alu_req_ready = 1'b1;
      alu_resp_valid = 1'b0;
      alu_resp = '0;
      alu_resp_tag = '0;
      alu_resp_data = '0;
      for (int p = 0; p < 4; p++) begin cmd_v[p] = '0; dat_v[p] = '0; end
      #12;
      check("rst_valid", alu_req_valid, 0);
      check("rst_cmd", alu_cmd, 0);
      check("rst_tag", alu_tag, 0);
      for (int p = 0; p < 4; p++) check("rst_resp", o_resp[p], 0);
      reset_n = 1'b1;
      tick;
      // all four ports in the same cycle, two back-to-back rounds
      rr_round;
      rr_round;
      tick;
      // stalled ALU with ports 1 and 3 pending
      alu_req_ready = 1'b0;
      send(4'b0101, CMD_ADD, 32'h10, 32'h20);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", alu_req_valid, 1);
         check("stall_tag", alu_tag, 0);
         check("stall_cmd", alu_cmd, CMD_ADD);
         check("stall_op1", alu_op1, 32'h10);
         check("stall_op2", alu_op2, 32'h20);
         if (i == 1) begin cmd_v[0] = CMD_SUB; dat_v[0] = 32'h99; end
         if (i == 2) begin cmd_v[0] = CMD_NOP; dat_v[0] = '0; end
         tick;
      end
      alu_req_ready = 1'b1;
      check("stall_keep_tag", alu_tag, 0);
      tick;
      check("stall_next_valid", alu_req_valid, 1);
      check("stall_next_tag", alu_tag, 2);
      check("stall_next_op1", alu_op1, 32'h12);
      tick;
      check("stall_drained", alu_req_valid, 0);
      // out-of-order completion: port 3 busy, port 4 issued after it
      send(4'b1000, CMD_SHL, 32'd5, 32'd0);
      check("ooo_tag", alu_tag, 3);
      check("ooo_cmd", alu_cmd, CMD_SHL);
      tick;
      check("ooo_idle", alu_req_valid, 0);
      result(2'd3, RESP_ERR, 32'd0);
      check("ooo_resp4", o_resp[3], RESP_ERR);
      check("ooo_data4", o_data[3], 0);
      check("ooo_resp3_early", o_resp[2], 0);
      result(2'd2, RESP_OK, 32'hABC);
      check("ooo_resp3", o_resp[2], RESP_OK);
      check("ooo_data3", o_data[2], 32'hABC);
      check("ooo_resp4_gone", o_resp[3], 0);
      result(2'd1, RESP_OK, 32'h123);
      check("stray_resp2", o_resp[1], 0);
      check("stray_data2", o_data[1], 0);
      result(2'd0, RESP_OK, 32'h30);
      check("rel_resp1", o_resp[0], RESP_OK);
      check("rel_data1", o_data[0], 32'h30);
      // single add on port 1
      send(4'b0001, CMD_ADD, 32'h1, 32'h1FF_FFFF);
      check("add_valid", alu_req_valid, 1);
      check("add_tag", alu_tag, 0);
      check("add_cmd", alu_cmd, CMD_ADD);
      check("add_op1", alu_op1, 32'h1);
      check("add_op2", alu_op2, 32'h1FF_FFFF);
      tick;
      check("add_single", alu_req_valid, 0);
      result(2'd0, RESP_OK, 32'h200_0000);
      check("add_resp", o_resp[0], RESP_OK);
      check("add_data", o_data[0], 32'h200_0000);
      for (int p = 1; p < 4; p++) check("add_other", o_resp[p], 0);
      tick;
      check("add_resp_1cyc", o_resp[0], 0);
      check("add_data_1cyc", o_data[0], 0);
      // invalid commands on port 2, answered locally
      for (int i = 0; i < 2; i++) begin
         send(4'b0010, 4'(3 + i), 32'h5, 32'h6);
         check("inv_noreq", alu_req_valid, 0);
         check("inv_early", o_resp[1], 0);
         tick;
         check("inv_resp", o_resp[1], RESP_ERR);
         check("inv_data", o_data[1], 0);
         check("inv_noreq2", alu_req_valid, 0);
         tick;
         check("inv_resp_1cyc", o_resp[1], 0);
      end
      // asynchronous reset with busy and pending ports
      send(4'b1000, CMD_ADD, 32'h1, 32'h2);
      tick;
      send(4'b0010, CMD_ADD, 32'h7, 32'h8);
      tick;
      alu_req_ready = 1'b0;
      send(4'b0100, CMD_SUB, 32'h9, 32'h4);
      check("pre_rst_tag", alu_tag, 2);
      result(2'd3, RESP_OK, 32'h55);
      check("pre_rst_resp4", o_resp[3], RESP_OK);
      check("pre_rst_valid", alu_req_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", alu_req_valid, 0);
      check("arst_cmd", alu_cmd, 0);
      check("arst_op1", alu_op1, 0);
      check("arst_op2", alu_op2, 0);
      check("arst_tag", alu_tag, 0);
      check("arst_resp4", o_resp[3], 0);
      check("arst_data4", o_data[3], 0);
      tick;
      reset_n = 1'b1;
      alu_req_ready = 1'b1;
      result(2'd1, RESP_OK, 32'h77);
      check("late_resp2", o_resp[1], 0);
      check("late_data2", o_data[1], 0);
      check("late_valid", alu_req_valid, 0);
      send(4'b0110, CMD_ADD, 32'h40, 32'h50);
      check("fresh_tag_a", alu_tag, 1);
      check("fresh_op1_a", alu_op1, 32'h41);
      tick;
      check("fresh_tag_b", alu_tag, 2);
      check("fresh_op1_b", alu_op1, 32'h42);
      tick;
      check("fresh_idle", alu_req_valid, 0);
      result(2'd1, RESP_OK, 32'h91);
      check("fresh_resp2", o_resp[1], RESP_OK);
      check("fresh_data2", o_data[1], 32'h91);
      result(2'd2, RESP_OK, 32'h93);
      check("fresh_resp3", o_resp[2], RESP_OK);
      check("fresh_data3", o_data[2], 32'h93);
      tick;
      for (int p = 0; p < 4; p++) check("final_quiet", o_resp[p], 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/calc1_port_sched.md
# calc1_port_sched

Request scheduler in front of the shared calc1 ALU.
- Accepts two-cycle requests on four independent requester ports and round-robin arbitrates pending requests onto a single ready/valid ALU issue interface.
- Routes tagged, possibly out-of-order ALU results back to the originating port as one-cycle responses.
- Answers invalid commands locally without using the ALU.

## Interface
- NPORTS, 4: number of requester ports (fixed at 4 for this release).
- DW, 32: operand/result width.

- c_clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- reqN_cmd_in  in  [0:3]  command for port N (N=1..4); 0 = no request.
- reqN_data_in  in  [0:DW-1]  operand 1 in the command cycle, operand 2 in the following cycle.
- out_respN  out  [0:1]  per-port response; 0 none, 1 success, 2 error (overflow/underflow/invalid), 3 reserved.
- out_dataN  out  [0:DW-1]  per-port result; valid when out_respN != 0.
- alu_req_valid  out  1  issue request to the ALU.
- alu_req_ready  in  1  ALU accepts the request.
- alu_cmd  out  [0:3]  issued command.
- alu_op1, alu_op2  out  [0:DW-1]  issued operands.
- alu_tag  out  [0:1]  originating port (0..3).
- alu_resp_valid  in  1  ALU result strobe.
- alu_resp  in  [0:1]  ALU response code (1 or 2).
- alu_resp_data  in  [0:DW-1]  ALU result.
- alu_resp_tag  in  [0:1]  port the result belongs to.

## Operation
Command codes:
- Valid: 1 add, 2 sub, 5 shift left, 6 shift right.
- Invalid: any other nonzero code.

Per-port state machine:
- IDLE → OP2 on a nonzero cmd; capture cmd and operand 1.
- OP2 → PEND after capturing operand 2 from reqN_data_in, if the cmd is valid.
- OP2 → ERR if the cmd is invalid.
- ERR → IDLE after driving out_respN=2, out_dataN=0 for one cycle.
- PEND → BUSY when granted and alu_req_ready=1.
- BUSY → IDLE when alu_resp_valid=1 with alu_resp_tag equal to this port. On that edge the port registers alu_resp/alu_resp_data onto out_respN/out_dataN.
- A port holds at most one outstanding request. Nonzero cmds arriving in OP2/PEND/ERR/BUSY are ignored.

Arbitration:
- Round-robin among PEND ports. The search starts at the port after the last granted one; after reset it starts at port 1.
- alu_req_valid = any port in PEND.
- cmd, operands and tag reflect the winner. They are held stable, and the winner is not changed, until alu_req_ready=1.
- The pointer advances only on a handshake.

Results:
- Results may return in any order.
- A result whose tag names a port not in BUSY is dropped.
- At most 4 requests are in flight.

Outputs:
- out_respN and out_dataN are 0 in every cycle without a response.

## Timing
- cmd sampled at edge T; operand 2 sampled at edge T+1.
- The port is PEND from T+1 onward, so alu_req_valid can be high in the cycle after T+1.
- With an idle ALU and alu_req_ready=1, the handshake completes at edge T+2.
- Invalid cmd: out_respN=2 in the cycle after edge T+2, for exactly one cycle.
- Result: alu_resp_valid sampled at edge R → out_respN/out_dataN valid in the cycle after R, for one cycle only. The port accepts a new cmd sampled at edge R+1 or later.
- Multiple results for different ports are impossible (single result bus). Simultaneous issue and result for different ports are independent.
- reset_n low, at any time:
  - all ports to IDLE, RR pointer to port 1;
  - alu_req_valid, alu_cmd, alu_op1, alu_op2, alu_tag, out_respN and out_dataN all 0 immediately (asynchronous).
  - Results arriving after reset are dropped, because every port is IDLE.

## Structure
- Package calc1_pkg holds:
  - command constants (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR);
  - response constants (RESP_NONE, RESP_OK, RESP_ERR);
  - the port-state enum (IDLE, OP2, PEND, ERR, BUSY);
  - NPORTS and DW.
- Sub-module calc1_port_ctrl holds one port's state machine, capture registers and response register; it is instantiated four times.
- The top level contains the round-robin arbiter, the issue mux and the result demux.

## Test plan
- Port 1 add 1h, 1FF_FFFFh; ALU ready, echoes result 200_0000h, resp 1 → single issue with alu_tag=0; out_resp1=1, out_data1=200_0000h for one cycle; other ports 0.
- Ports 1–4 all issue sub in the same cycle; alu_req_ready=1 constantly → grants in order tags 0,1,2,3. Repeat immediately → next round also 0,1,2,3.
- Port 2 issues cmd 3, then cmd 4 → no ALU request; out_resp2=2, out_data2=0, two cycles after each cmd edge.
- alu_req_ready=0 for 5 cycles with ports 1 and 3 pending → alu_cmd/op/tag=0 stable for 5 cycles. A new cmd on port 1 during the wait is ignored.
- Out-of-order: port 3 issued before port 4; ALU returns tag 3 (resp 2, data 0), then tag 2 → out_resp4=2 first, then out_resp3. A stray tag-1 result with port 2 idle → no response.
- reset_n pulsed low while ports are BUSY → all outputs 0 immediately. Late ALU results are dropped. A fresh add then completes normally with tag search starting at port 1.
